// File: rtl/sm_hex_scan.sv
// Time-multiplexed hex display scanner with a double-buffered digit image,
// leading-zero blanking, per-digit decimal point and per-digit blinking.
module sm_hex_scan #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 4096,
    parameter int GAP            = 64,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  bph;
    logic [4*DIGITS-1:0]   sh_data, act_data;
    logic [DIGITS-1:0]     sh_dp, act_dp;
    logic [DIGITS-1:0]     sh_blink, act_blink;

    logic                  pre_wrap, idx_wrap, frame_end;
    logic [DIGITS-1:0]     sel;
    logic [DIGITS-1:0]     upper_zero;
    logic [3:0]            nibble;
    logic                  digit_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign pre_wrap  = (pre == PW'(SCAN_DIV - 1));
    assign idx_wrap  = (idx == IW'(DIGITS - 1));
    assign frame_end = pre_wrap && idx_wrap;

    // upper_zero[i] is set when every active nibble from the top digit down to i is zero
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        upper_zero = '0;
        sel        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero && (act_data[4*i +: 4] == 4'h0);
            upper_zero[i] = run_zero;
            sel[i]        = (idx == IW'(i));
        end
        nibble   = act_data[{idx, 2'b00} +: 4];
        digit_on = !((blank_lz && (idx != '0) && upper_zero[idx]) ||
                     (act_blink[idx] && bph));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            idx       <= '0;
            fcnt      <= '0;
            bph       <= 1'b0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blink <= '0;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap)
                idx <= idx_wrap ? '0 : idx + 1'b1;
            if (frame_end) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt <= '0;
                    bph  <= ~bph;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp_in;
                sh_blink <= blink_en;
            end
            // The displayed image only swaps at a frame boundary; a load landing on
            // that very cycle bypasses the shadow so it is not delayed a whole frame.
            if (frame_end) begin
                act_data  <= load ? data     : sh_data;
                act_dp    <= load ? dp_in    : sh_dp;
                act_blink <= load ? blink_en : sh_blink;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode      <= AN_OFF;
            seg        <= SEG_OFF;
            seg_dp     <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            anode      <= ((pre >= PW'(GAP)) ? sel : '0) ^ AN_OFF;
            seg        <= (digit_on ? hex_to_seg(nibble) : 7'h00) ^ SEG_OFF;
            seg_dp     <= (digit_on && act_dp[idx]) ^ DP_OFF;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_sm_hex_scan.sv
// Scoreboard bench for sm_hex_scan: expected pin values come from a closed-form
// view of the scan position and the digit image each frame should show.
module tb_sm_hex_scan;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int GP    = 1;
    localparam int BF    = 2;
    localparam int FRAME = SD * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fr_data[8];
    logic [3:0]  fr_dp[8];
    logic [3:0]  fr_blink[8];

    sm_hex_scan #(
        .DIGITS(ND), .SCAN_DIV(SD), .GAP(GP), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .load(load), .dp_in(dp_in),
        .blink_en(blink_en), .blank_lz(blank_lz), .anode(anode), .seg(seg),
        .seg_dp(seg_dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Output seen in cycle n reflects scan state s = n-1 counted from reset release
    function automatic exp_t calc(int n, logic [15:0] d, logic [3:0] dpv, logic [3:0] bl, logic blz);
        exp_t       e;
        int         s, pre, idx, fr;
        logic       bph, blank;
        logic [3:0] an;
        s     = n - 1;
        pre   = s % SD;
        idx   = (s / SD) % ND;
        fr    = s / FRAME;
        bph   = ((fr / BF) % 2) == 1;
        an    = '0;
        if (pre >= GP) an[idx] = 1'b1;
        blank = (blz && idx > 0 && ((d >> (4 * idx)) == 16'h0)) || (bl[idx] && bph);
        e.n   = n;
        e.an  = ~an;
        e.seg = blank ? 7'h7F : ~hex7(d[4*idx +: 4]);
        e.dp  = blank ? 1'b1 : ~dpv[idx];
        e.fd  = (pre == SD - 1) && (idx == ND - 1);
        return e;
    endfunction

    task automatic clear_frames();
        for (int f = 0; f < 8; f++) begin
            fr_data[f]  = '0;
            fr_dp[f]    = '0;
            fr_blink[f] = '0;
        end
    endtask

    task automatic push_expect(input int ncyc, input logic blz);
        exp_q.delete();
        for (int n = 1; n <= ncyc; n++)
            exp_q.push_back(calc(n, fr_data[(n-1)/FRAME], fr_dp[(n-1)/FRAME], fr_blink[(n-1)/FRAME], blz));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        load     = 1'b0;
        data     = '0;
        dp_in    = '0;
        blink_en = '0;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        #1;
        checks++;
        if ({anode, seg, seg_dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL reset_value: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
                     anode, seg, seg_dp, frame_done);
        end
        do_reset();
        clear_frames();
        push_expect(34, 1'b0);
        for (int n = 1; n <= 34; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL scan cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        do_reset();
        clear_frames();
        fr_data[1] = 16'h1234;
        fr_data[2] = 16'h1234;
        push_expect(40, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL load cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            load = (n == 3);
            if (n == 3) data = 16'h1234;
        end
        load = 1'b0;
    endtask

    task automatic test_leading_zero();
        exp_t e;
        do_reset();
        blank_lz = 1'b1;
        clear_frames();
        fr_data[1] = 16'h0050;
        fr_data[2] = 16'h0050;
        push_expect(64, 1'b1);
        for (int n = 1; n <= 64; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL leading_zero cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            load = (n == 2) || (n == 33);
            if (n == 2)  data = 16'h0050;
            if (n == 33) data = 16'h0000;
        end
        load     = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        exp_t e;
        do_reset();
        clear_frames();
        for (int f = 1; f < 8; f++) begin
            fr_data[f]  = 16'h1234;
            fr_dp[f]    = 4'b0101;
            fr_blink[f] = 4'b0001;
        end
        push_expect(96, 1'b0);
        for (int n = 1; n <= 96; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL blink cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            load = (n == 2);
            if (n == 2) begin
                data     = 16'h1234;
                dp_in    = 4'b0101;
                blink_en = 4'b0001;
            end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        clear_frames();
        fr_data[1] = 16'h1111;
        fr_data[2] = 16'hABCD;
        fr_data[3] = 16'h5678;
        push_expect(64, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL boundary_load cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
            load = (n == 5) || (n == 31) || (n == 40) || (n == 41);
            case (n)
                5:       data = 16'h1111;
                31:      data = 16'hABCD;
                40:      data = 16'h9999;
                41:      data = 16'h5678;
                default: data = 16'hEEEE;
            endcase
        end
        load = 1'b0;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        do_reset();
        clear_frames();
        push_expect(10, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL pre_reset cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({anode, seg, seg_dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL async_reset: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
                     anode, seg, seg_dp, frame_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({anode, seg, seg_dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL held_reset: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
                     anode, seg, seg_dp, frame_done);
        end
        rst = 1'b0;
        cyc = 0;
        push_expect(20, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({anode, seg, seg_dp, frame_done} !== {e.an, e.seg, e.dp, e.fd}) begin
                fails++;
                $display("[TB] FAIL restart cycle %0d: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         e.n, anode, seg, seg_dp, frame_done, e.an, e.seg, e.dp, e.fd);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load();
        test_leading_zero();
        test_blink();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
